// File: rtl/button_blip_gen.sv
// Up/down push-button front end: synchronise, debounce, press blip with optional
// hold auto-repeat, and a registered output stage gated by the game window.

module button_blip_chan #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic Clk100M,
    input  logic reset,
    input  logic btn,
    output logic db,
    output logic blip
);

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST   = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEAT} stateT;

    logic             syncA, syncB;
    logic [CNT_W-1:0] dbCnt;
    logic [CNT_W-1:0] rCnt, rCntNext;
    stateT            state, stateNext;

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= btn;
            syncB <= syncA;
        end
    end

    // Counter only runs while the synced level disagrees with db; any match restarts it.
    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            db    <= 1'b0;
            dbCnt <= '0;
        end else if (syncB == db) begin
            dbCnt <= '0;
        end else if (dbCnt == DB_LAST) begin
            db    <= ~db;
            dbCnt <= '0;
        end else begin
            dbCnt <= dbCnt + 1'b1;
        end
    end

    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            rCnt  <= '0;
        end else begin
            state <= stateNext;
            rCnt  <= rCntNext;
        end
    end

    // IDLE with db high can only follow a db rising edge, so it marks a fresh press.
    always_comb begin
        stateNext = state;
        rCntNext  = rCnt;
        blip      = 1'b0;
        if (!db) begin
            stateNext = ST_IDLE;
            rCntNext  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    blip      = 1'b1;
                    stateNext = ST_PRESSED;
                    rCntNext  = '0;
                end
                ST_PRESSED: begin
                    if (REPEAT_EN) begin
                        if (rCnt == DELAY_LAST) begin
                            blip      = 1'b1;
                            stateNext = ST_REPEAT;
                            rCntNext  = '0;
                        end else begin
                            rCntNext = rCnt + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (rCnt == PER_LAST) begin
                        blip     = 1'b1;
                        rCntNext = '0;
                    end else begin
                        rCntNext = rCnt + 1'b1;
                    end
                end
                default: begin
                    stateNext = ST_IDLE;
                    rCntNext  = '0;
                end
            endcase
        end
    end

endmodule

module button_blip_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic Clk100M,
    input  logic reset,
    input  logic enable,
    input  logic btnUp,
    input  logic btnDown,
    output logic up,
    output logic down,
    output logic dbUp,
    output logic dbDown
);

    logic rawUp, rawDown;

    button_blip_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .CNT_W          (CNT_W)
    ) upChan (
        .Clk100M(Clk100M),
        .reset  (reset),
        .btn    (btnUp),
        .db     (dbUp),
        .blip   (rawUp)
    );

    button_blip_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (REPEAT_EN),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_PERIOD  (REPEAT_PERIOD),
        .CNT_W          (CNT_W)
    ) downChan (
        .Clk100M(Clk100M),
        .reset  (reset),
        .btn    (btnDown),
        .db     (dbDown),
        .blip   (rawDown)
    );

    // Coincident blips cancel; masked blips are dropped rather than held.
    always_ff @(posedge Clk100M or negedge reset) begin
        if (!reset) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= rawUp & enable & ~rawDown;
            down <= rawDown & enable & ~rawUp;
        end
    end

endmodule
